// File: rtl/iram_axi_arb.sv
// Two-master AXI4-Lite arbiter in front of the instruction RAM slave port.
// Build option: define IRAM_ARB_FIXED_PRIO_EN for fixed priority (master 0 wins ties).
module iram_axi_arb #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  // master 0
  input  logic [ADDR_W-1:0]   m0_awaddr,
  input  logic [2:0]          m0_awprot,
  input  logic                m0_awvalid,
  output logic                m0_awready,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  input  logic                m0_wvalid,
  output logic                m0_wready,
  output logic [1:0]          m0_bresp,
  output logic                m0_bvalid,
  input  logic                m0_bready,
  input  logic [ADDR_W-1:0]   m0_araddr,
  input  logic [2:0]          m0_arprot,
  input  logic                m0_arvalid,
  output logic                m0_arready,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic [1:0]          m0_rresp,
  output logic                m0_rvalid,
  input  logic                m0_rready,
  // master 1
  input  logic [ADDR_W-1:0]   m1_awaddr,
  input  logic [2:0]          m1_awprot,
  input  logic                m1_awvalid,
  output logic                m1_awready,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  input  logic                m1_wvalid,
  output logic                m1_wready,
  output logic [1:0]          m1_bresp,
  output logic                m1_bvalid,
  input  logic                m1_bready,
  input  logic [ADDR_W-1:0]   m1_araddr,
  input  logic [2:0]          m1_arprot,
  input  logic                m1_arvalid,
  output logic                m1_arready,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic [1:0]          m1_rresp,
  output logic                m1_rvalid,
  input  logic                m1_rready,
  // RAM slave
  output logic [ADDR_W-1:0]   s_awaddr,
  output logic [2:0]          s_awprot,
  output logic                s_awvalid,
  input  logic                s_awready,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  output logic                s_wvalid,
  input  logic                s_wready,
  input  logic [1:0]          s_bresp,
  input  logic                s_bvalid,
  output logic                s_bready,
  output logic [ADDR_W-1:0]   s_araddr,
  output logic [2:0]          s_arprot,
  output logic                s_arvalid,
  input  logic                s_arready,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic [1:0]          s_rresp,
  input  logic                s_rvalid,
  output logic                s_rready
);

  typedef enum logic [1:0] {StIdle, StWrResp, StRdWait} state_e;

  state_e r_state, w_state_d;
  logic   r_gnt, w_gnt_d;
  logic   r_last, w_last_d;

  logic w_wreq0, w_wreq1, w_req0, w_req1;
  logic w_win, w_win_wreq, w_win_rreq;
  logic w_idle, w_fwd_wr, w_fwd_rd, w_wr_acc, w_rd_acc;
  logic w_in_wr, w_in_rd, w_gnt_bready, w_gnt_rready;
  logic w_unused;

  // The RAM B channel is permanently valid; responses are generated locally.
  assign w_unused = s_bvalid;

  assign w_wreq0 = m0_awvalid & m0_wvalid;
  assign w_wreq1 = m1_awvalid & m1_wvalid;
  assign w_req0  = w_wreq0 | m0_arvalid;
  assign w_req1  = w_wreq1 | m1_arvalid;

`ifdef IRAM_ARB_FIXED_PRIO_EN
  assign w_win = (w_req0 & w_req1) ? 1'b0 : w_req1;
`else
  assign w_win = (w_req0 & w_req1) ? ~r_last : w_req1;
`endif

  assign w_win_wreq = w_win ? w_wreq1 : w_wreq0;
  assign w_win_rreq = w_win ? m1_arvalid : m0_arvalid;

  // Reset gates every handshake so outputs take reset values immediately.
  assign w_idle   = (r_state == StIdle) & ~rst;
  assign w_in_wr  = (r_state == StWrResp) & ~rst;
  assign w_in_rd  = (r_state == StRdWait) & ~rst;
  assign w_fwd_wr = w_idle & w_win_wreq;
  assign w_fwd_rd = w_idle & ~w_win_wreq & w_win_rreq;
  assign w_wr_acc = w_fwd_wr & s_awready & s_wready;
  assign w_rd_acc = w_fwd_rd & s_arready;

  assign w_gnt_bready = r_gnt ? m1_bready : m0_bready;
  assign w_gnt_rready = r_gnt ? m1_rready : m0_rready;

  assign s_awaddr  = w_win ? m1_awaddr : m0_awaddr;
  assign s_awprot  = w_win ? m1_awprot : m0_awprot;
  assign s_wdata   = w_win ? m1_wdata  : m0_wdata;
  assign s_wstrb   = w_win ? m1_wstrb  : m0_wstrb;
  assign s_araddr  = w_win ? m1_araddr : m0_araddr;
  assign s_arprot  = w_win ? m1_arprot : m0_arprot;
  assign s_awvalid = w_fwd_wr;
  assign s_wvalid  = w_fwd_wr;
  assign s_arvalid = w_fwd_rd;
  assign s_bready  = 1'b1;
  // Outside a granted read, any stray RAM read response is drained.
  assign s_rready  = w_in_rd ? w_gnt_rready : 1'b1;

  assign m0_awready = w_wr_acc & ~w_win;
  assign m1_awready = w_wr_acc & w_win;
  assign m0_wready  = w_wr_acc & ~w_win;
  assign m1_wready  = w_wr_acc & w_win;
  assign m0_arready = w_rd_acc & ~w_win;
  assign m1_arready = w_rd_acc & w_win;

  assign m0_bvalid = w_in_wr & ~r_gnt;
  assign m1_bvalid = w_in_wr & r_gnt;
  assign m0_bresp  = (w_in_wr & ~r_gnt) ? s_bresp : 2'b00;
  assign m1_bresp  = (w_in_wr & r_gnt) ? s_bresp : 2'b00;

  assign m0_rvalid = w_in_rd & ~r_gnt & s_rvalid;
  assign m1_rvalid = w_in_rd & r_gnt & s_rvalid;
  assign m0_rdata  = (w_in_rd & ~r_gnt) ? s_rdata : '0;
  assign m1_rdata  = (w_in_rd & r_gnt) ? s_rdata : '0;
  assign m0_rresp  = (w_in_rd & ~r_gnt) ? s_rresp : 2'b00;
  assign m1_rresp  = (w_in_rd & r_gnt) ? s_rresp : 2'b00;

  always_comb begin
    w_state_d = r_state;
    w_gnt_d   = r_gnt;
    w_last_d  = r_last;
    unique case (r_state)
      StIdle: begin
        if (w_wr_acc) begin
          w_state_d = StWrResp;
          w_gnt_d   = w_win;
          w_last_d  = w_win;
        end else if (w_rd_acc) begin
          w_state_d = StRdWait;
          w_gnt_d   = w_win;
          w_last_d  = w_win;
        end
      end
      StWrResp: if (w_gnt_bready) w_state_d = StIdle;
      StRdWait: if (s_rvalid & w_gnt_rready) w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_gnt   <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_d;
      r_gnt   <= w_gnt_d;
      r_last  <= w_last_d;
    end
  end

endmodule

// File: tb/tb_iram_axi_arb.sv
// Self-checking bench for iram_axi_arb: RAM model, per-master BFMs, grant/response scoreboard.
module tb_iram_axi_arb;

  localparam int Tmo = 100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0][31:0] awaddr, wdata, araddr, rdata;
  logic [1:0][3:0]  wstrb;
  logic [1:0][2:0]  awprot, arprot;
  logic [1:0][1:0]  bresp, rresp;
  logic [1:0] awvalid, wvalid, bready, arvalid, rready;
  logic [1:0] awready, wready, bvalid, arready, rvalid;

  logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
  logic [2:0]  s_awprot, s_arprot;
  logic [3:0]  s_wstrb;
  logic [1:0]  s_bresp, s_rresp;
  logic s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic s_arvalid, s_arready, s_rvalid, s_rready;

  iram_axi_arb #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .m0_awaddr(awaddr[0]), .m0_awprot(awprot[0]), .m0_awvalid(awvalid[0]),
    .m0_awready(awready[0]), .m0_wdata(wdata[0]), .m0_wstrb(wstrb[0]),
    .m0_wvalid(wvalid[0]), .m0_wready(wready[0]), .m0_bresp(bresp[0]),
    .m0_bvalid(bvalid[0]), .m0_bready(bready[0]), .m0_araddr(araddr[0]),
    .m0_arprot(arprot[0]), .m0_arvalid(arvalid[0]), .m0_arready(arready[0]),
    .m0_rdata(rdata[0]), .m0_rresp(rresp[0]), .m0_rvalid(rvalid[0]), .m0_rready(rready[0]),
    .m1_awaddr(awaddr[1]), .m1_awprot(awprot[1]), .m1_awvalid(awvalid[1]),
    .m1_awready(awready[1]), .m1_wdata(wdata[1]), .m1_wstrb(wstrb[1]),
    .m1_wvalid(wvalid[1]), .m1_wready(wready[1]), .m1_bresp(bresp[1]),
    .m1_bvalid(bvalid[1]), .m1_bready(bready[1]), .m1_araddr(araddr[1]),
    .m1_arprot(arprot[1]), .m1_arvalid(arvalid[1]), .m1_arready(arready[1]),
    .m1_rdata(rdata[1]), .m1_rresp(rresp[1]), .m1_rvalid(rvalid[1]), .m1_rready(rready[1]),
    .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready)
  );

  // RAM slave model: one-cycle read latency, not reset by the arbiter reset.
  logic [31:0] ram [64];
  logic        ram_rvalid = 1'b0;
  logic [31:0] ram_rdata  = 32'h0;

  initial for (int i = 0; i < 64; i++) ram[i] = 32'hA5A5_0000 | 32'(i);

  assign s_awready = 1'b1;
  assign s_wready  = 1'b1;
  assign s_bvalid  = 1'b1;
  assign s_bresp   = 2'b00;
  assign s_arready = ~ram_rvalid;
  assign s_rvalid  = ram_rvalid;
  assign s_rdata   = ram_rvalid ? ram_rdata : 32'h0;
  assign s_rresp   = 2'b00;

  always @(posedge clk) begin
    if (s_awvalid && s_wvalid && s_awready && s_wready)
      for (int b = 0; b < 4; b++)
        if (s_wstrb[b]) ram[s_awaddr[7:2]][8*b +: 8] <= s_wdata[8*b +: 8];
    if (s_arvalid && s_arready) begin
      ram_rvalid <= 1'b1;
      ram_rdata  <= ram[s_araddr[7:2]];
    end else if (ram_rvalid && s_rready) begin
      ram_rvalid <= 1'b0;
    end
  end

  int n_vec = 0;
  int n_err = 0;
  int q_gnt [$];
  logic [31:0] exp_r0 [$];
  logic [31:0] exp_r1 [$];
  logic [1:0]  exp_b0 [$];
  logic [1:0]  exp_b1 [$];
  logic [31:0] ref_mem [int];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    if (ref_mem.exists(int'(a[7:2]))) return ref_mem[int'(a[7:2])];
    return 32'hA5A5_0000 | {26'd0, a[7:2]};
  endfunction

  // Scoreboard: grant order and response data are popped as the DUT produces them.
  always @(negedge clk) begin
    if (!rst) begin
      for (int m = 0; m < 2; m++) begin
        if ((arvalid[m] && arready[m]) ||
            (awvalid[m] && wvalid[m] && awready[m] && wready[m])) begin
          if (q_gnt.size() == 0) check("gnt_extra", 0, 1);
          else check("gnt_order", m, q_gnt.pop_front());
        end
        if (rvalid[m] && rready[m]) begin
          check("rresp", rresp[m], 2'b00);
          if (m == 0) begin
            if (exp_r0.size() == 0) check("rd_extra0", 0, 1);
            else check("rdata0", rdata[0], exp_r0.pop_front());
          end else begin
            if (exp_r1.size() == 0) check("rd_extra1", 0, 1);
            else check("rdata1", rdata[1], exp_r1.pop_front());
          end
        end
        if (bvalid[m] && bready[m]) begin
          if (m == 0) begin
            if (exp_b0.size() == 0) check("b_extra0", 0, 1);
            else check("bresp0", bresp[0], exp_b0.pop_front());
          end else begin
            if (exp_b1.size() == 0) check("b_extra1", 0, 1);
            else check("bresp1", bresp[1], exp_b1.pop_front());
          end
        end
      end
    end
  end

  task automatic mwr(input int m, input logic [31:0] a, input logic [31:0] d, input int bdly);
    int n = 0;
    awaddr[m] = a; wdata[m] = d; wstrb[m] = 4'hF; awprot[m] = 3'b000;
    awvalid[m] = 1'b1; wvalid[m] = 1'b1; bready[m] = 1'b0;
    ref_mem[int'(a[7:2])] = d;
    if (m == 0) exp_b0.push_back(2'b00); else exp_b1.push_back(2'b00);
    @(negedge clk);
    while (!(awready[m] && wready[m]) && n < Tmo) begin @(negedge clk); n++; end
    check("wr_grant", {awready[m], wready[m]}, 2'b11);
    check("wr_noar", s_arvalid, 1'b0);
    @(posedge clk); #1;
    awvalid[m] = 1'b0; wvalid[m] = 1'b0; bready[m] = (bdly == 0);
    @(negedge clk);
    check("wr_blat", bvalid[m], 1'b1);
    for (int k = 0; k < bdly; k++) begin
      check("wr_bhold", bvalid[m], 1'b1);
      check("wr_nogrant", {arready[1-m], awready[1-m]}, 2'b00);
      @(posedge clk); #1;
      if (k == bdly - 1) bready[m] = 1'b1;
      @(negedge clk);
    end
    check("wr_bdone", bvalid[m], 1'b1);
    @(posedge clk); #1;
    bready[m] = 1'b0;
  endtask

  task automatic mrd(input int m, input logic [31:0] a, input int dly);
    int n = 0;
    logic [31:0] e;
    e = exp_word(a);
    araddr[m] = a; arprot[m] = 3'b000; arvalid[m] = 1'b1; rready[m] = 1'b0;
    if (m == 0) exp_r0.push_back(e); else exp_r1.push_back(e);
    @(negedge clk);
    while (!arready[m] && n < Tmo) begin @(negedge clk); n++; end
    check("rd_grant", arready[m], 1'b1);
    check("rd_noaw", awready[m], 1'b0);
    @(posedge clk); #1;
    arvalid[m] = 1'b0; rready[m] = (dly == 0);
    @(negedge clk);
    check("rd_lat", rvalid[m], 1'b1);
    for (int k = 0; k < dly; k++) begin
      check("rd_hold_v", rvalid[m], 1'b1);
      check("rd_hold_d", rdata[m], e);
      check("rd_nogrant", arready[1-m], 1'b0);
      @(posedge clk); #1;
      if (k == dly - 1) rready[m] = 1'b1;
      @(negedge clk);
    end
    check("rd_done", rvalid[m], 1'b1);
    @(posedge clk); #1;
    rready[m] = 1'b0;
  endtask

  task automatic check_reset_outs();
    check("rst_mvalid", {bvalid, rvalid}, 4'h0);
    check("rst_mready", {awready, wready, arready}, 6'h0);
    check("rst_rdata", rdata, 64'h0);
    check("rst_svalid", {s_awvalid, s_wvalid, s_arvalid}, 3'b000);
    check("rst_sready", {s_bready, s_rready}, 2'b11);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    awvalid = '0; wvalid = '0; arvalid = '0; bready = '0; rready = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outs();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    awaddr = '0; wdata = '0; araddr = '0; wstrb = '0; awprot = '0; arprot = '0;
    do_reset();
    @(negedge clk);
    check("idle_sready", {s_bready, s_rready, s_arvalid, s_awvalid}, 4'b1100);
    @(posedge clk); #1;

    // single write then read-back from m0
    q_gnt.push_back(0); q_gnt.push_back(0);
    mwr(0, 32'h10, 32'hDEAD_BEEF, 0);
    mrd(0, 32'h10, 0);

    // simultaneous m0 write and m1 read straight after reset
    do_reset();
    q_gnt.push_back(0); q_gnt.push_back(1);
    fork
      mwr(0, 32'h18, 32'hCAFE_F00D, 3);
      mrd(1, 32'h24, 0);
    join

    // continuous contention: four reads each
`ifdef IRAM_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 4; i++) q_gnt.push_back(0);
    for (int i = 0; i < 4; i++) q_gnt.push_back(1);
`else
    for (int i = 0; i < 4; i++) begin q_gnt.push_back(0); q_gnt.push_back(1); end
`endif
    fork
      begin for (int i = 0; i < 4; i++) mrd(0, 32'h40 + 32'(4 * i), 0); end
      begin for (int i = 0; i < 4; i++) mrd(1, 32'h80 + 32'(4 * i), 0); end
    join

    // m1 stalls rready for 5 cycles while m0 waits
    q_gnt.push_back(1); q_gnt.push_back(0);
    fork
      mrd(1, 32'h84, 5);
      begin @(posedge clk); #1; mrd(0, 32'h44, 0); end
    join

    // reset one cycle after an m0 read handshake
    begin
      int n = 0;
      q_gnt.push_back(0);
      araddr[0] = 32'h30; arvalid[0] = 1'b1; rready[0] = 1'b0;
      @(negedge clk);
      while (!arready[0] && n < Tmo) begin @(negedge clk); n++; end
      check("rst_rd_grant", arready[0], 1'b1);
      @(posedge clk); #1;
      arvalid[0] = 1'b0; rst = 1'b1;
      araddr[1] = 32'h34; arvalid[1] = 1'b1;
      repeat (2) begin
        @(negedge clk);
        check_reset_outs();
        @(posedge clk); #1;
      end
      rst = 1'b0; arvalid[1] = 1'b0;
      @(negedge clk);
      check("rst_nofwd", rvalid, 2'b00);
      @(posedge clk); #1;
      q_gnt.push_back(1);
      mrd(1, 32'h34, 0);
    end

    // write request without wvalid: read goes first, write follows later
    q_gnt.push_back(0); q_gnt.push_back(0); q_gnt.push_back(1);
    awaddr[0] = 32'h50; wdata[0] = 32'h1234_5678; wstrb[0] = 4'hF;
    awvalid[0] = 1'b1; wvalid[0] = 1'b0;
    mrd(0, 32'h20, 0);
    repeat (2) begin
      @(negedge clk);
      check("wr_wait_nowv", {awready[0], wready[0], s_awvalid}, 3'b000);
    end
    @(posedge clk); #1;
    mwr(0, 32'h50, 32'h1234_5678, 1);
    mrd(1, 32'h50, 0);

    repeat (3) @(posedge clk);
    check("sb_gnt", q_gnt.size(), 0);
    check("sb_rd", exp_r0.size() + exp_r1.size(), 0);
    check("sb_wr", exp_b0.size() + exp_b1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/iram_axi_arb.md
# iram_axi_arb

Two-master AXI4-Lite arbiter placed in front of the instruction RAM's AXI4-Lite slave port. It shares that port between master 0 (ISP/loader path) and master 1 (debug/system bus path). Arbitration is per transaction; each grant is held until that transaction's response completes. Write responses are generated locally, because the RAM's own B channel is permanently valid.

## Interface
Parameters:
- ADDR_W, 32, byte-address width on all ports
- DATA_W, 32, data width; strobe width is DATA_W/8

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- m0_awaddr/m0_awprot/m0_awvalid  in  ADDR_W/3/1  master 0 write address
- m0_awready  out  1
- m0_wdata/m0_wstrb/m0_wvalid  in  DATA_W/4/1  master 0 write data
- m0_wready  out  1
- m0_bresp/m0_bvalid  out  2/1; m0_bready  in  1
- m0_araddr/m0_arprot/m0_arvalid  in  ADDR_W/3/1; m0_arready  out  1
- m0_rdata/m0_rresp/m0_rvalid  out  DATA_W/2/1; m0_rready  in  1
- m1_*  same set as m0_*, for master 1
- s_awaddr, s_awprot, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready, s_araddr, s_arprot, s_arvalid, s_rready  out  to the RAM slave
- s_awready, s_wready, s_bresp, s_bvalid, s_arready, s_rdata, s_rresp, s_rvalid  in  from the RAM slave

## Operation
- States: IDLE, WR_RESP, RD_WAIT. Register `gnt` (1 bit) holds the owning master. Register `last` holds the previously granted master.
- Request from master i: wreq_i = awvalid&wvalid; rreq_i = arvalid; req_i = wreq_i|rreq_i.
- IDLE, winner selection (combinational):
  - Only one master requests: it wins.
  - Both request: the master ≠ `last` wins (round-robin).
- IDLE, forwarding:
  - The winner's AW/W/AR signals pass to s_*; the loser's ready outputs stay 0.
  - If the winner has wreq, only AW/W are forwarded and s_arvalid=0. Write beats read within a master.
- Write accept (IDLE, s_awready&s_wready): the winner sees awready=wready=1 that cycle. Then gnt←winner, last←winner, state→WR_RESP.
- WR_RESP: m[gnt]_bvalid=1, bresp=s_bresp. On bready → IDLE.
- Read accept (IDLE, s_arready): the winner sees arready=1. Then gnt←winner, last←winner, state→RD_WAIT.
- RD_WAIT: m[gnt]_rvalid/rdata/rresp mirror s_*; s_rready=m[gnt]_rready. On s_rvalid&m[gnt]_rready → IDLE.
- No new slave address/data handshake is issued outside IDLE.
- In IDLE, s_bready=1 and s_rready=1, so any stray RAM read response (e.g. after a reset abort) is drained. Read data arriving in IDLE is never forwarded.
- Non-granted master: all valid/ready outputs 0, rdata 0, resp 00.

## Timing
- Reset state: IDLE, last=1 (so master 0 wins the first tie), gnt=0. All m*_ outputs 0. s_*valid 0, s_bready/s_rready 1.
- Reset asserted mid-transaction aborts it: outputs take reset values immediately, and the pending response is dropped.
- Write: handshake in cycle N; m_bvalid high from N+1 until bready. The earliest next grant is the cycle after bready is sampled.
- Read: handshake in cycle N; the RAM returns rvalid in N+1 and it is forwarded in N+1 (combinational). The earliest next grant is the cycle after rvalid&rready.
- Back-to-back contention alternates masters: 0,1,0,1.
- A master may drop valid in IDLE before it is granted; no state changes.
- s_* outputs depend combinationally on master inputs in IDLE. No combinational path from m*_ready to s_*valid.

## Configuration
- IRAM_ARB_FIXED_PRIO_EN defined: master 0 always wins ties and `last` is ignored. Master 1 can starve.
- Undefined: round-robin as above.

## Test plan
- Single write from m0 (awaddr=0x10, wdata=0xDEADBEEF, wstrb=F) → awready/wready=1 in cycle N; m0_bvalid=1, bresp=00 from N+1. A subsequent m0 read of 0x10 returns 0xDEADBEEF with rresp=00.
- Simultaneous m0 write and m1 read from reset → m0 is granted first. m1 arready appears only after m0 bready; m1 rdata equals the RAM contents.
- Both masters issue 4 continuous reads each → grant order 0,1,0,1,0,1,0,1. With IRAM_ARB_FIXED_PRIO_EN: four m0 grants, then four m1.
- m1 holds rready=0 for 5 cycles with rvalid high → rvalid/rdata stay stable, no new grant occurs, and m0 arvalid waits with arready=0.
- Assert rst one cycle after an m0 read handshake → all outputs 0 during reset. After release, the stray s_rvalid is drained and not forwarded, and the next m1 read completes normally.
- m0 has awvalid=1 and arvalid=1 with wvalid=0 → the read is forwarded and no write is accepted. The write completes once wvalid rises on a later cycle.
